// File: rtl/fifo_pkg.sv
// Shared definitions for the async FIFO read/write pointer controllers.
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int PTR_MAX        = 32;

  // Pointers narrower than PTR_MAX are zero-extended in and truncated out.
  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin = gray;
    for (int s = 1; s < PTR_MAX; s = s * 2) bin = bin ^ (bin >> s);
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module fifo_gray2bin #(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^gray[WIDTH-1:i];
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer and flag controller for the async FIFO: owns the read
// pointer and derives empty/almost-empty/level/underflow from the synced wptr.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ADDR_WIDTH:0]   i_rq2_wptr,
  input  logic                  i_rd_en,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic [ADDR_WIDTH:0]   o_rd_ptr_gray,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_rd_level,
  output logic                  o_underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AE_THRESH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rgray;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] level_next;
  logic             pop;

  fifo_gray2bin #(.WIDTH(PTR_W)) u_wptr_g2b (
    .gray (i_rq2_wptr),
    .bin  (wbin)
  );

  assign pop        = i_rd_en & ~o_empty;
  assign rbin_next  = rbin + {{ADDR_WIDTH{1'b0}}, pop};
  assign rgray_next = PTR_W'(bin2gray(PTR_MAX'(rbin_next)));
  // Modular difference stays correct across the MSB wrap of either pointer.
  assign level_next = wbin - rbin_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rbin        <= '0;
      rgray       <= '0;
      o_empty     <= 1'b1;
      o_aempty    <= 1'b1;
      o_rd_level  <= '0;
      o_underflow <= 1'b0;
    end else begin
      rbin        <= rbin_next;
      rgray       <= rgray_next;
      o_empty     <= (rgray_next == i_rq2_wptr);
      o_aempty    <= (level_next <= AE_THRESH);
      o_rd_level  <= level_next;
      o_underflow <= i_rd_en & o_empty;
    end
  end

  assign o_rd_addr     = rbin[ADDR_WIDTH-1:0];
  assign o_rd_ptr_gray = rgray;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a vector table plus wrap, simultaneous
// pop/write and asynchronous reset sequences.
module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] rq2_wptr = '0;
  logic       rd_en = 1'b0;
  logic [4:0] rd_addr;
  logic [5:0] rd_ptr_gray;
  logic       empty;
  logic       aempty;
  logic [5:0] rd_level;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  fifo_rd_ctrl #(.ADDR_WIDTH(5), .AEMPTY_THRESH(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rq2_wptr    (rq2_wptr),
    .i_rd_en       (rd_en),
    .o_rd_addr     (rd_addr),
    .o_rd_ptr_gray (rd_ptr_gray),
    .o_empty       (empty),
    .o_aempty      (aempty),
    .o_rd_level    (rd_level),
    .o_underflow   (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic [6:0] wbin;
    logic [5:0] rbin;
    logic       empty;
    logic       aempty;
    logic [5:0] level;
    logic       uf;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [5:0] g(input logic [6:0] b);
    logic [5:0] t;
    t = b[5:0];
    return t ^ (t >> 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic rd, input logic [6:0] wbin);
    @(negedge clk);
    rd_en    = rd;
    rq2_wptr = g(wbin);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [5:0] rbin, input logic e,
                         input logic ae, input logic [5:0] lvl, input logic uf);
    chk({tag, " addr"},  int'(rd_addr),     int'(rbin[4:0]));
    chk({tag, " gray"},  int'(rd_ptr_gray), int'(g({1'b0, rbin})));
    chk({tag, " empty"}, int'(empty),       int'(e));
    chk({tag, " aempty"},int'(aempty),      int'(ae));
    chk({tag, " level"}, int'(rd_level),    int'(lvl));
    chk({tag, " uflow"}, int'(underflow),   int'(uf));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rd_en    = 1'b0;
    rq2_wptr = '0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [5:0] prev_gray;

    //          rd    wbin   rbin  empty aempty level  uf
    vecs[0] = '{1'b0, 7'd3, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0};
    vecs[1] = '{1'b1, 7'd3, 6'd1, 1'b0, 1'b1, 6'd2, 1'b0};
    vecs[2] = '{1'b1, 7'd3, 6'd2, 1'b0, 1'b1, 6'd1, 1'b0};
    vecs[3] = '{1'b1, 7'd3, 6'd3, 1'b1, 1'b1, 6'd0, 1'b0};
    vecs[4] = '{1'b1, 7'd3, 6'd3, 1'b1, 1'b1, 6'd0, 1'b1};
    vecs[5] = '{1'b0, 7'd3, 6'd3, 1'b1, 1'b1, 6'd0, 1'b0};
    vecs[6] = '{1'b0, 7'd8, 6'd3, 1'b0, 1'b0, 6'd5, 1'b0};
    vecs[7] = '{1'b1, 7'd9, 6'd4, 1'b0, 1'b0, 6'd5, 1'b0};
    vecs[8] = '{1'b1, 7'd9, 6'd5, 1'b0, 1'b1, 6'd4, 1'b0};
    vecs[9] = '{1'b1, 7'd9, 6'd6, 1'b0, 1'b1, 6'd3, 1'b0};

    // Reset asserted before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk_all("reset", 6'd0, 1'b1, 1'b1, 6'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].rd, vecs[i].wbin);
      chk_all($sformatf("vec%0d", i), vecs[i].rbin, vecs[i].empty,
              vecs[i].aempty, vecs[i].level, vecs[i].uf);
    end

    // Wrap: fill to 32 via Gray steps, drain, repeat to pointer 64.
    do_reset();
    for (int w = 1; w <= 32; w++) step(1'b0, 7'(w));
    chk_all("fill32", 6'd0, 1'b0, 1'b0, 6'd32, 1'b0);
    prev_gray = rd_ptr_gray;
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 7'd32);
      chk($sformatf("wrap1 addr%0d", i), int'(rd_addr), i % 32);
      chk("wrap1 gray 1bit", int'($countones(rd_ptr_gray ^ prev_gray)), 1);
      prev_gray = rd_ptr_gray;
    end
    chk_all("drain32", 6'd32, 1'b1, 1'b1, 6'd0, 1'b0);
    chk("drain32 gray", int'(rd_ptr_gray), 6'b110000);
    for (int w = 33; w <= 64; w++) step(1'b0, 7'(w));
    chk_all("fill64", 6'd32, 1'b0, 1'b0, 6'd32, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 7'd64);
      chk("wrap2 gray 1bit", int'($countones(rd_ptr_gray ^ prev_gray)), 1);
      prev_gray = rd_ptr_gray;
    end
    chk_all("drain64", 6'd0, 1'b1, 1'b1, 6'd0, 1'b0);

    // Asynchronous reset mid-operation at rbin=5, level=2.
    do_reset();
    step(1'b0, 7'd7);
    for (int i = 0; i < 5; i++) step(1'b1, 7'd7);
    chk_all("pre_rst", 6'd5, 1'b0, 1'b1, 6'd2, 1'b0);
    @(negedge clk);
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    rq2_wptr = '0;
    #1;
    chk_all("async_rst", 6'd0, 1'b1, 1'b1, 6'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7'd0);
    chk_all("post_rst pop", 6'd0, 1'b1, 1'b1, 6'd0, 1'b1);
    step(1'b0, 7'd0);
    chk_all("post_rst idle", 6'd0, 1'b1, 1'b1, 6'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
